avalon_dct_mac: RTL and testbench

//  Avalon-MM slave DCT engine; second generation of our DCT peripheral. It replaces the
//  all-terms-combinational sum with one time-multiplexed multiply-accumulate (MAC).
//  It supports two transforms, DCT-I and DCT-II, chosen by a mode register.
//  The CPU loads the size and samples, then reads coefficients; reads of a coefficient
//  not yet computed stall on waitrequest.

---
 rtl/avalon_dct_mac.sv | 225 ++++++++++++++++++++++
 tb/tb_avalon_dct_mac.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_dct_mac.sv
// ---------------------------------------------------------------------------
// avalon_dct_mac
//   Avalon-MM slave DCT engine with one time-multiplexed multiply-accumulate.
//   The CPU selects DCT-I or DCT-II, writes START with the transform size,
//   streams the samples through DATA and then reads coefficients from the
//   result region. A read of a coefficient that is not yet computed stalls
//   on waitrequest until its writeback cycle.
//
//   Handshake: writes never stall. A read completes on the first rising edge
//   of clk at which waitrequest is low. waitrequest only rises for a read of
//   a result index below the current size whose result is not yet valid.
//
//   Build option: DCT_SAT_EN defined   -> writeback saturates to NBITS signed
//                 DCT_SAT_EN undefined -> writeback keeps the low NBITS bits
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   address      in   [MSB]=1 result region (index in low bits), else register
//   read         in   Avalon read strobe
//   write        in   Avalon write strobe
//   writedata    in   write data (NBITS)
//   readdata     out  read data, combinational from address (NBITS)
//   waitrequest  out  stall the current read
//   o_dbg_state  out  FSM state (0 IDLE, 1 LOAD, 2 COMPUTE, 3 DONE)
// ---------------------------------------------------------------------------
module avalon_dct_mac #(
  parameter int MAX_SIZE  = 128,
  parameter int NBITS     = 16,
  parameter int ACC_BITS  = 40,
  parameter int ADDR_BITS = $clog2(MAX_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] address,
  input  logic                 read,
  input  logic                 write,
  input  logic [NBITS-1:0]     writedata,
  output logic [NBITS-1:0]     readdata,
  output logic                 waitrequest,
  output logic [1:0]           o_dbg_state
);

  localparam int  IDX_BITS = ADDR_BITS - 1;
  localparam int  TAB      = 4 * MAX_SIZE;
  localparam int  TAB_BITS = $clog2(TAB);
  localparam int  NUM_W    = 2 * ADDR_BITS + $clog2(MAX_SIZE) + 1;
  localparam real PI       = 3.14159265358979323846;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic signed [ACC_BITS-1:0] SAT_MAX =
    {{(ACC_BITS-NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] SAT_MIN =
    {{(ACC_BITS-NBITS+1){1'b1}}, {(NBITS-1){1'b0}}};

  // Quarter-period-resolution cosine, Q(NBITS-1); entry 0 would be +1.0,
  // which does not fit, so it is pinned to the largest positive code.
  function automatic logic signed [NBITS-1:0] cos_entry(input int i);
    real r;
    int  v;
    r = $cos(PI * i / (2.0 * MAX_SIZE)) * real'(1 << (NBITS-1));
    v = $rtoi(r);
    if (i == 0) v = (1 << (NBITS-1)) - 1;
    return NBITS'(v);
  endfunction

  logic signed [NBITS-1:0] w_cos_rom [0:TAB-1];
  for (genvar g = 0; g < TAB; g++) begin : g_cos
    assign w_cos_rom[g] = cos_entry(g);
  end

  logic [1:0]                  r_state;
  logic [ADDR_BITS-1:0]        r_size;
  logic                        r_mode;
  logic                        r_size_err;
  logic [ADDR_BITS-1:0]        r_ld_k;
  logic [ADDR_BITS-1:0]        r_n;
  logic [ADDR_BITS-1:0]        r_k;
  logic signed [ACC_BITS-1:0]  r_acc;
  logic [MAX_SIZE-1:0]         r_valid;
  logic signed [NBITS-1:0]     r_x   [0:MAX_SIZE-1];
  logic [NBITS-1:0]            r_res [0:MAX_SIZE-1];

  // Bus decode
  logic                 w_is_res, w_reg_sel, w_start, w_data, w_mode_wr;
  logic [IDX_BITS-1:0]  w_ridx;
  assign w_is_res  = address[ADDR_BITS-1];
  assign w_reg_sel = !w_is_res && (address[ADDR_BITS-2:2] == '0);
  assign w_start   = write && w_reg_sel && (address[1:0] == 2'd0);
  assign w_data    = write && w_reg_sel && (address[1:0] == 2'd1);
  assign w_mode_wr = write && w_reg_sel && (address[1:0] == 2'd2);
  assign w_ridx    = address[IDX_BITS-1:0];

  // START size check; DCT-I needs size-1 to be a power of two so that the
  // table step 2*MAX_SIZE/(size-1) is exact.
  logic [NBITS-1:0] w_sm1;
  logic             w_pow2, w_wd_ok;
  assign w_sm1   = writedata - NBITS'(1);
  assign w_pow2  = ((w_sm1 & (w_sm1 - NBITS'(1))) == '0);
  assign w_wd_ok = (writedata >= NBITS'(2)) && (writedata <= NBITS'(MAX_SIZE)) &&
                   (r_mode || w_pow2);

  // Cosine index for the current (n, k) term
  logic [ADDR_BITS:0]  w_nfac;
  logic [NUM_W-1:0]    w_num, w_den, w_den_raw;
  logic [TAB_BITS-1:0] w_idx;
  assign w_nfac    = r_mode ? {r_n, 1'b1} : {r_n, 1'b0};
  assign w_num     = NUM_W'(w_nfac) * NUM_W'(r_k) * NUM_W'(MAX_SIZE);
  assign w_den_raw = r_mode ? NUM_W'(r_size) : NUM_W'(r_size) - NUM_W'(1);
  assign w_den     = (w_den_raw == '0) ? NUM_W'(1) : w_den_raw;
  assign w_idx     = TAB_BITS'(w_num / w_den);

  // One product per cycle; DCT-I end points carry half weight
  logic signed [NBITS-1:0]    w_xn, w_cos;
  logic signed [2*NBITS-1:0]  w_prod, w_term;
  logic signed [ACC_BITS-1:0] w_term_ext, w_shift;
  logic                       w_half, w_wb_cyc;
  logic [NBITS-1:0]           w_wb;
  assign w_xn       = r_x[r_n[IDX_BITS-1:0]];
  assign w_cos      = w_cos_rom[w_idx];
  assign w_prod     = w_xn * w_cos;
  assign w_half     = !r_mode && ((r_n == '0) || (r_n == r_size - ADDR_BITS'(1)));
  assign w_term     = w_half ? (w_prod >>> 1) : w_prod;
  assign w_term_ext = {{(ACC_BITS-2*NBITS){w_term[2*NBITS-1]}}, w_term};
  assign w_wb_cyc   = (r_state == S_COMPUTE) && (r_n == r_size);
  assign w_shift    = r_acc >>> (NBITS-1);

`ifdef DCT_SAT_EN
  assign w_wb = (w_shift > SAT_MAX) ? NBITS'(SAT_MAX) :
                (w_shift < SAT_MIN) ? NBITS'(SAT_MIN) : NBITS'(w_shift);
`else
  logic w_unused_sat;
  assign w_unused_sat = ^{SAT_MAX, SAT_MIN};
  assign w_wb = NBITS'(w_shift);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_size     <= '0;
      r_mode     <= 1'b0;
      r_size_err <= 1'b0;
      r_ld_k     <= '0;
      r_n        <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_valid    <= '0;
    end else if (w_start) begin
      // START also aborts any run in progress; nothing partial is kept
      r_valid <= '0;
      r_acc   <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_ld_k  <= '0;
      if (w_wd_ok) begin
        r_size     <= writedata[ADDR_BITS-1:0];
        r_size_err <= 1'b0;
        r_state    <= S_LOAD;
      end else begin
        // Size 0 keeps every result read from stalling while in error
        r_size     <= '0;
        r_size_err <= 1'b1;
        r_state    <= S_IDLE;
      end
    end else begin
      if (w_mode_wr && ((r_state == S_IDLE) || (r_state == S_DONE)))
        r_mode <= writedata[0];
      case (r_state)
        S_LOAD: begin
          if (w_data) begin
            r_ld_k <= r_ld_k + ADDR_BITS'(1);
            if (r_ld_k == r_size - ADDR_BITS'(1)) r_state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          if (!w_wb_cyc) begin
            r_acc <= r_acc + w_term_ext;
            r_n   <= r_n + ADDR_BITS'(1);
          end else begin
            r_valid[r_k[IDX_BITS-1:0]] <= 1'b1;
            r_acc <= '0;
            r_n   <= '0;
            r_k   <= r_k + ADDR_BITS'(1);
            if (r_k == r_size - ADDR_BITS'(1)) r_state <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample and result storage need no reset: result_valid guards reads
  always_ff @(posedge clk) begin
    if ((r_state == S_LOAD) && w_data && !w_start)
      r_x[r_ld_k[IDX_BITS-1:0]] <= writedata;
    if (w_wb_cyc && !w_start)
      r_res[r_k[IDX_BITS-1:0]] <= w_wb;
  end

  logic w_busy, w_all_done;
  assign w_busy      = (r_state == S_LOAD) || (r_state == S_COMPUTE);
  assign w_all_done  = (r_state == S_DONE);
  assign o_dbg_state = r_state;

  // A read together with a write is not a legal Avalon cycle: return 0
  always_comb begin
    readdata    = '0;
    waitrequest = 1'b0;
    if (!write) begin
      if (w_is_res) begin
        if ({1'b0, w_ridx} < r_size) begin
          if (r_valid[w_ridx]) readdata = r_res[w_ridx];
          else                 waitrequest = read;
        end
      end else if (w_reg_sel && (address[1:0] == 2'd3)) begin
        readdata = NBITS'({r_mode, r_size_err, w_all_done, w_busy});
      end
    end
  end

endmodule

// File: tb/tb_avalon_dct_mac.sv
// ---------------------------------------------------------------------------
// tb_avalon_dct_mac
//   Bench for avalon_dct_mac. Expected coefficients come from a direct
//   evaluation of the DCT sums over a cosine table built with $cos.
// ---------------------------------------------------------------------------
module tb_avalon_dct_mac;

  localparam int  MAX_SIZE  = 128;
  localparam int  NBITS     = 16;
  localparam int  ADDR_BITS = 8;
  localparam int  RD_BUDGET = 20000;
  localparam real PI        = 3.14159265358979323846;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [ADDR_BITS-1:0] address;
  logic                 read, write;
  logic [NBITS-1:0]     writedata, readdata;
  logic                 waitrequest;
  logic [1:0]           dbg_state;

  avalon_dct_mac #(.MAX_SIZE(MAX_SIZE), .NBITS(NBITS), .ACC_BITS(40), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int               n_total = 0;
  int               n_bad   = 0;
  int               cos_q   [4*MAX_SIZE];
  int               x_buf   [MAX_SIZE];
  logic [NBITS-1:0] got_res [MAX_SIZE];
  logic [NBITS-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: X[k] = sum_n w(n) * x[n] * cos_q[idx(n,k)], then >>> (NBITS-1)
  function automatic logic [NBITS-1:0] model_coef(input int mode, input int size, input int k);
    longint acc;
    longint term;
    longint v;
    int     idx;
    acc = 0;
    for (int n = 0; n < size; n++) begin
      if (mode == 0) idx = (2 * n * k * MAX_SIZE / (size - 1)) % (4 * MAX_SIZE);
      else           idx = ((2 * n + 1) * k * MAX_SIZE / size) % (4 * MAX_SIZE);
      term = longint'(x_buf[n]) * longint'(cos_q[idx]);
      if (mode == 0 && (n == 0 || n == size - 1)) term = term >>> 1;
      acc += term;
    end
    v = acc >>> (NBITS - 1);
`ifdef DCT_SAT_EN
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v[NBITS-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [ADDR_BITS-1:0] a, input logic [NBITS-1:0] d);
    address = a; writedata = d; write = 1'b1; read = 1'b0;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [ADDR_BITS-1:0] a, output logic [NBITS-1:0] d, output int stall);
    address = a; read = 1'b1; write = 1'b0; stall = 0;
    #1;
    while (waitrequest && stall < RD_BUDGET) begin
      @(posedge clk); #1;
      stall++;
    end
    if (waitrequest) check_eq("rd_timeout", 32'(stall), 32'(0));
    d = readdata;
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic read_status(output logic [NBITS-1:0] s);
    int st;
    bus_read(8'd3, s, st);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_samples(input int size);
    for (int n = 0; n < size; n++) bus_write(8'd1, 16'(x_buf[n]));
  endtask

  task automatic load_run(input int mode, input int size);
    bus_write(8'd2, 16'(mode));
    bus_write(8'd0, 16'(size));
    load_samples(size);
  endtask

  task automatic check_results(input int mode, input int size, input string tag);
    logic [NBITS-1:0] d;
    int st;
    for (int k = 0; k < size; k++) exp_q.push_back(model_coef(mode, size, k));
    for (int k = 0; k < size; k++) begin
      bus_read(8'(128 + k), d, st);
      got_res[k] = d;
      check_eq($sformatf("%s_k%0d", tag, k), 32'(d), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic rand_samples(input int size);
    for (int n = 0; n < size; n++) x_buf[n] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [NBITS-1:0] s, d;
    int cyc, st, sv;
    int mode, size;
    int d1_sizes[5] = '{2, 3, 5, 9, 17};

    for (int i = 0; i < 4 * MAX_SIZE; i++)
      cos_q[i] = $rtoi($cos(PI * i / (2.0 * MAX_SIZE)) * real'(1 << (NBITS-1)));
    cos_q[0] = 32767;

    reset = 1'b1; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_readdata", 32'(readdata), 32'(0));
    check_eq("rst_waitreq", 32'(waitrequest), 32'(0));
    check_eq("rst_state", 32'(dbg_state), 32'(0));
    reset = 1'b0;
    idle(1);
    read_status(s);
    check_eq("rst_status", 32'(s), 32'(0));

    // 1: DCT-II, size 4, constant input
    for (int n = 0; n < 4; n++) x_buf[n] = 1000;
    load_run(1, 4);
    cyc = 0; address = 8'd3; read = 1'b1;
    #1;
    while (!readdata[1] && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    read = 1'b0;
    check_eq("t1_done_cycles", 32'(cyc), 32'(20));
    check_results(1, 4, "t1");
    check_eq("t1_x0", 32'(got_res[0]), 32'(3999));
    for (int k = 1; k < 4; k++) begin
      sv = int'($signed(got_res[k]));
      check_eq($sformatf("t1_small_k%0d", k), 32'(sv <= 2 && sv >= -2), 32'(1));
    end

    // 2: DCT-I, size 5, impulse
    x_buf[0] = 2000;
    for (int n = 1; n < 5; n++) x_buf[n] = 0;
    load_run(0, 5);
    check_results(0, 5, "t2");
    for (int k = 0; k < 5; k++) check_eq($sformatf("t2_const_k%0d", k), 32'(got_res[k]), 32'(999));

    // 3: stall on the last coefficient right after the last DATA write
    rand_samples(4);
    load_run(1, 4);
    bus_read(8'h83, d, st);
    check_eq("t3_stall", 32'(st), 32'(20));
    check_eq("t3_x3", 32'(d), 32'(model_coef(1, 4, 3)));

    // 4: full-scale input, writeback overflow
    for (int n = 0; n < 4; n++) x_buf[n] = 32767;
    load_run(1, 4);
    check_results(1, 4, "t4");
`ifdef DCT_SAT_EN
    check_eq("t4_x0", 32'(got_res[0]), 32'h7FFF);
`else
    check_eq("t4_x0", 32'(got_res[0]), 32'hFFF8);
`endif

    // 5: START aborts a running compute, then reset mid-compute
    rand_samples(4);
    load_run(1, 4);
    idle(8);
    bus_write(8'd0, 16'd8);
    read_status(s);
    check_eq("t5_status", 32'(s), 32'h9);
    address = 8'h80; read = 1'b1;
    #1;
    check_eq("t5_stall", 32'(waitrequest), 32'(1));
    read = 1'b0;
    rand_samples(8);
    load_samples(8);
    check_results(1, 8, "t5");

    rand_samples(4);
    load_run(1, 4);
    idle(7);
    reset = 1'b1; address = 8'd3; read = 1'b1;
    #1;
    check_eq("t5_rst_status", 32'(readdata), 32'(0));
    check_eq("t5_rst_state", 32'(dbg_state), 32'(0));
    read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
    bus_read(8'h81, d, st);
    check_eq("t5_rst_nostall", 32'(st), 32'(0));
    check_eq("t5_rst_data", 32'(d), 32'(0));

    // 6: illegal sizes
    bus_write(8'd0, 16'd1);
    read_status(s);
    check_eq("t6_size1", 32'(s), 32'h4);
    bus_write(8'd1, 16'd5);
    read_status(s);
    check_eq("t6_data_ign", 32'(s), 32'h4);
    check_eq("t6_state", 32'(dbg_state), 32'(0));
    bus_write(8'd0, 16'd129);
    read_status(s);
    check_eq("t6_size129", 32'(s), 32'h4);
    bus_write(8'd2, 16'd0);
    bus_write(8'd0, 16'd4);
    read_status(s);
    check_eq("t6_dct1_size4", 32'(s), 32'h4);
    bus_write(8'd0, 16'd3);
    read_status(s);
    check_eq("t6_recover", 32'(s), 32'h1);
    bus_write(8'd2, 16'd1);
    read_status(s);
    check_eq("t6_mode_locked", 32'(s), 32'h1);
    rand_samples(3);
    load_samples(3);
    check_results(0, 3, "t6");

    // Index beyond size reads 0 without stalling
    bus_read(8'h8A, d, st);
    check_eq("oob_stall", 32'(st), 32'(0));
    check_eq("oob_data", 32'(d), 32'(0));

    // Read and write together: write takes effect, read returns 0
    bus_write(8'd2, 16'd1);
    address = 8'd3; read = 1'b1; write = 1'b1; writedata = '0;
    #1;
    check_eq("rw_same_cycle", 32'(readdata), 32'(0));
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    read_status(s);
    check_eq("rw_status", 32'(s), 32'hA);

    // Randomized runs, plus the largest sizes
    for (int r = 0; r < 8; r++) begin
      mode = int'($urandom_range(0, 1));
      size = (mode == 1) ? int'($urandom_range(2, 16)) : d1_sizes[$urandom_range(0, 4)];
      rand_samples(size);
      load_run(mode, size);
      check_results(mode, size, $sformatf("rnd%0d", r));
    end
    rand_samples(65);
    load_run(0, 65);
    check_results(0, 65, "max_dct1");
    rand_samples(128);
    load_run(1, 128);
    check_results(1, 128, "max_dct2");
    read_status(s);
    check_eq("final_status", 32'(s), 32'hA);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
